// File: rtl/vx_matrix_commit_merge.sv
// Merges per-micro-op matrix commits into one macro-commit per warp macro instruction.
// Latency: macro-commit is registered, valid the cycle after the final micro-op handshake.
// Backpressure: single output slot; in_ready = !out_valid || out_ready, and a stalled slot freezes all trackers.
module vx_matrix_commit_merge #(
  parameter int NUM_WARPS  = 4,
  parameter int NW_BITS    = 2,
  parameter int UUID_WIDTH = 44,
  parameter int MI_BITS    = 2,
  parameter logic [MI_BITS-1:0] MLOAD_ID = MI_BITS'(1),
  parameter logic [MI_BITS-1:0] MMUL_ID  = MI_BITS'(2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NW_BITS-1:0]    in_wid,
  input  logic [UUID_WIDTH-1:0] in_uuid,
  input  logic [MI_BITS-1:0]    in_m_instr_id,
  input  logic [3:0]            in_m_idx,
  input  logic [3:0]            in_m_row_size,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NW_BITS-1:0]    out_wid,
  output logic [UUID_WIDTH-1:0] out_uuid,
  output logic [MI_BITS-1:0]    out_m_instr_id,
  output logic [4:0]            out_count,
  output logic [NUM_WARPS-1:0]  busy,
  output logic                  err_dup,
  output logic                  err_range,
  output logic                  err_uuid
);

  // Per-warp tracker state
  logic [NUM_WARPS-1:0]  trk_open;
  logic [UUID_WIDTH-1:0] trk_uuid [NUM_WARPS];
  logic [MI_BITS-1:0]    trk_id   [NUM_WARPS];
  logic [4:0]            trk_e    [NUM_WARPS];
  logic [15:0]           trk_mask [NUM_WARPS];

  // Decode of the incoming micro-op against its warp's tracker
  logic        accept;
  logic        is_mat;
  logic [4:0]  e_in;
  logic [4:0]  eff_e;
  logic        cur_open;
  logic        cur_match;
  logic [15:0] bit_sel;
  logic [15:0] full_mask;
  logic [15:0] base_mask;
  logic [15:0] new_mask;
  logic        range_err;
  logic        uuid_err;
  logic        dup_err;
  logic        mat_ok;
  logic        complete;
  logic        emit;
  logic [4:0]  emit_count;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = trk_open;

  // Classify the micro-op, compute the updated mask and pick the single error (range > uuid > dup)
  always_comb begin
    is_mat     = (in_m_instr_id == MLOAD_ID) || (in_m_instr_id == MMUL_ID);
    // MMUL carries one extra micro-op; 5-bit sum so row_size 15 gives 16
    e_in       = (in_m_instr_id == MMUL_ID) ? ({1'b0, in_m_row_size} + 5'd1)
                                            : {1'b0, in_m_row_size};
    cur_open   = trk_open[in_wid];
    cur_match  = (trk_uuid[in_wid] == in_uuid) && (trk_id[in_wid] == in_m_instr_id);
    // An open, matching tracker owns the expected count latched at open time
    eff_e      = (cur_open && cur_match) ? trk_e[in_wid] : e_in;
    bit_sel    = 16'd1 << in_m_idx;
    full_mask  = (eff_e >= 5'd16) ? 16'hFFFF : ((16'd1 << eff_e) - 16'd1);
    base_mask  = cur_open ? trk_mask[in_wid] : 16'd0;
    new_mask   = base_mask | bit_sel;
    range_err  = is_mat && (({1'b0, in_m_idx} >= eff_e) ||
                            ((in_m_instr_id == MLOAD_ID) && (in_m_row_size == 4'd0)));
    uuid_err   = is_mat && !range_err && cur_open && !cur_match;
    dup_err    = is_mat && !range_err && !uuid_err && cur_open && ((base_mask & bit_sel) != 16'd0);
    mat_ok     = is_mat && !range_err && !uuid_err && !dup_err;
    complete   = mat_ok && (new_mask == full_mask);
    emit       = !is_mat || complete;
    emit_count = is_mat ? eff_e : 5'd1;
  end

  // Tracker update: open/extend on a good micro-op, close on completion
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_open <= '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        trk_uuid[i] <= '0;
        trk_id[i]   <= '0;
        trk_e[i]    <= '0;
        trk_mask[i] <= '0;
      end
    end else if (accept && mat_ok) begin
      trk_open[in_wid] <= !complete;
      trk_uuid[in_wid] <= in_uuid;
      trk_id[in_wid]   <= in_m_instr_id;
      trk_e[in_wid]    <= eff_e;
      trk_mask[in_wid] <= complete ? 16'd0 : new_mask;
    end
  end

  // Output slot: reload on emit, otherwise drain when downstream takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_wid        <= '0;
      out_uuid       <= '0;
      out_m_instr_id <= '0;
      out_count      <= '0;
    end else if (accept && emit) begin
      out_valid      <= 1'b1;
      out_wid        <= in_wid;
      out_uuid       <= in_uuid;
      out_m_instr_id <= in_m_instr_id;
      out_count      <= emit_count;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

  // Error pulses, one cycle after the offending handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      err_dup   <= 1'b0;
      err_range <= 1'b0;
      err_uuid  <= 1'b0;
    end else begin
      err_dup   <= accept && dup_err;
      err_range <= accept && range_err;
      err_uuid  <= accept && uuid_err;
    end
  end

endmodule

// File: tb/tb_vx_matrix_commit_merge.sv
module tb_vx_matrix_commit_merge;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wid;
  logic [43:0] in_uuid;
  logic [1:0]  in_m_instr_id;
  logic [3:0]  in_m_idx;
  logic [3:0]  in_m_row_size;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_wid;
  logic [43:0] out_uuid;
  logic [1:0]  out_m_instr_id;
  logic [4:0]  out_count;
  logic [3:0]  busy;
  logic        err_dup;
  logic        err_range;
  logic        err_uuid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_matrix_commit_merge dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_uuid(in_uuid),
    .in_m_instr_id(in_m_instr_id), .in_m_idx(in_m_idx), .in_m_row_size(in_m_row_size),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_uuid(out_uuid),
    .out_m_instr_id(out_m_instr_id), .out_count(out_count), .busy(busy),
    .err_dup(err_dup), .err_range(err_range), .err_uuid(err_uuid)
  );

  // Advance one clock; outputs are observed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] w, input logic [43:0] u,
                       input logic [1:0] id, input logic [3:0] idx, input logic [3:0] rs);
    in_valid      = v;
    in_wid        = w;
    in_uuid       = u;
    in_m_instr_id = id;
    in_m_idx      = idx;
    in_m_row_size = rs;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'd0, 44'h0, 2'd0, 4'd0, 4'd0);
    tick();
    tick();
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (busy !== 4'b0000) begin bad++; $display("FAIL reset_busy got=%b want=0000", busy); end
    total++; if ({err_dup, err_range, err_uuid} !== 3'b000) begin bad++; $display("FAIL reset_err got=%b want=000", {err_dup, err_range, err_uuid}); end
    total++; if ({out_wid, out_uuid, out_m_instr_id, out_count} !== 53'd0) begin bad++; $display("FAIL reset_fields got=%0h want=0", {out_wid, out_uuid, out_m_instr_id, out_count}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_mload_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd1, 44'h10, 2'd1, 4'(i), 4'd4);
      tick();
      if (i < 3) begin
        total++; if (out_valid !== 1'b0 || busy[1] !== 1'b1) begin bad++; $display("FAIL mload_mid%0d got valid=%0b busy=%b want valid=0 busy[1]=1", i, out_valid, busy); end
      end
    end
    drive(1'b0, 2'd0, 44'h0, 2'd0, 4'd0, 4'd0);
    total++; if (out_valid !== 1'b1 || out_count !== 5'd4 || out_uuid !== 44'h10 || out_wid !== 2'd1 || out_m_instr_id !== 2'd1)
      begin bad++; $display("FAIL mload_commit got v=%0b cnt=%0d uuid=%0h wid=%0d id=%0d want v=1 cnt=4 uuid=10 wid=1 id=1", out_valid, out_count, out_uuid, out_wid, out_m_instr_id); end
    total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL mload_closed got busy=%b want busy[1]=0", busy); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mload_single_pulse got=%0b want=0", out_valid); end
  endtask

  task automatic test_mmul();
    logic [3:0] order [4] = '{4'd3, 4'd0, 4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd0, 44'h20, 2'd2, order[i], 4'd3);
      tick();
      if (i < 3) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mmul_early%0d got=%0b want=0", i, out_valid); end
      end
    end
    drive(1'b1, 2'd0, 44'h21, 2'd2, 4'd0, 4'd0);
    total++; if (out_valid !== 1'b1 || out_count !== 5'd4 || out_uuid !== 44'h20 || out_m_instr_id !== 2'd2)
      begin bad++; $display("FAIL mmul_commit got v=%0b cnt=%0d uuid=%0h id=%0d want v=1 cnt=4 uuid=20 id=2", out_valid, out_count, out_uuid, out_m_instr_id); end
    tick();
    drive(1'b0, 2'd0, 44'h0, 2'd0, 4'd0, 4'd0);
    total++; if (out_valid !== 1'b1 || out_count !== 5'd1 || out_uuid !== 44'h21 || busy !== 4'b0000)
      begin bad++; $display("FAIL mmul_row0 got v=%0b cnt=%0d uuid=%0h busy=%b want v=1 cnt=1 uuid=21 busy=0000", out_valid, out_count, out_uuid, busy); end
    tick();
  endtask

  task automatic test_normal_interleave();
    drive(1'b1, 2'd2, 44'h30, 2'd1, 4'd0, 4'd2);
    tick();
    drive(1'b1, 2'd2, 44'h31, 2'd0, 4'd0, 4'd0);
    tick();
    total++; if (out_valid !== 1'b1 || out_count !== 5'd1 || out_uuid !== 44'h31 || out_m_instr_id !== 2'd0 || busy[2] !== 1'b1)
      begin bad++; $display("FAIL normal_pass got v=%0b cnt=%0d uuid=%0h id=%0d busy=%b want v=1 cnt=1 uuid=31 id=0 busy[2]=1", out_valid, out_count, out_uuid, out_m_instr_id, busy); end
    drive(1'b1, 2'd2, 44'h30, 2'd1, 4'd1, 4'd2);
    tick();
    drive(1'b0, 2'd0, 44'h0, 2'd0, 4'd0, 4'd0);
    total++; if (out_valid !== 1'b1 || out_count !== 5'd2 || out_uuid !== 44'h30 || busy[2] !== 1'b0)
      begin bad++; $display("FAIL interleave_mload got v=%0b cnt=%0d uuid=%0h busy=%b want v=1 cnt=2 uuid=30 busy[2]=0", out_valid, out_count, out_uuid, busy); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 2'd3, 44'h40, 2'd1, 4'd0, 4'd1);
    tick();
    drive(1'b1, 2'd3, 44'h41, 2'd0, 4'd0, 4'd0);
    total++; if (out_valid !== 1'b1 || out_count !== 5'd1 || out_uuid !== 44'h40) begin bad++; $display("FAIL bp_load got v=%0b cnt=%0d uuid=%0h want v=1 cnt=1 uuid=40", out_valid, out_count, out_uuid); end
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0 || out_uuid !== 44'h40 || out_valid !== 1'b1)
        begin bad++; $display("FAIL bp_hold%0d got rdy=%0b v=%0b uuid=%0h want rdy=0 v=1 uuid=40", i, in_ready, out_valid, out_uuid); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_rdy got=%0b want=1", in_ready); end
    tick();
    drive(1'b0, 2'd0, 44'h0, 2'd0, 4'd0, 4'd0);
    total++; if (out_valid !== 1'b1 || out_uuid !== 44'h41 || out_wid !== 2'd3) begin bad++; $display("FAIL bp_reload got v=%0b uuid=%0h wid=%0d want v=1 uuid=41 wid=3", out_valid, out_uuid, out_wid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_errors();
    drive(1'b1, 2'd1, 44'h50, 2'd1, 4'd1, 4'd4);
    tick();
    drive(1'b1, 2'd1, 44'h50, 2'd1, 4'd1, 4'd4);
    tick();
    total++; if ({err_range, err_uuid, err_dup} !== 3'b001 || out_valid !== 1'b0) begin bad++; $display("FAIL err_dup got r/u/d=%b v=%0b want 001 v=0", {err_range, err_uuid, err_dup}, out_valid); end
    drive(1'b1, 2'd1, 44'h50, 2'd1, 4'd5, 4'd4);
    tick();
    total++; if ({err_range, err_uuid, err_dup} !== 3'b100 || out_valid !== 1'b0) begin bad++; $display("FAIL err_range_idx got r/u/d=%b v=%0b want 100 v=0", {err_range, err_uuid, err_dup}, out_valid); end
    drive(1'b1, 2'd1, 44'h51, 2'd1, 4'd2, 4'd4);
    tick();
    total++; if ({err_range, err_uuid, err_dup} !== 3'b010 || out_valid !== 1'b0) begin bad++; $display("FAIL err_uuid got r/u/d=%b v=%0b want 010 v=0", {err_range, err_uuid, err_dup}, out_valid); end
    drive(1'b1, 2'd1, 44'h51, 2'd1, 4'd7, 4'd4);
    tick();
    total++; if ({err_range, err_uuid, err_dup} !== 3'b100) begin bad++; $display("FAIL err_priority got r/u/d=%b want 100", {err_range, err_uuid, err_dup}); end
    drive(1'b1, 2'd0, 44'h52, 2'd1, 4'd0, 4'd0);
    tick();
    drive(1'b0, 2'd0, 44'h0, 2'd0, 4'd0, 4'd0);
    total++; if ({err_range, err_uuid, err_dup} !== 3'b100 || busy[0] !== 1'b0 || out_valid !== 1'b0)
      begin bad++; $display("FAIL err_row0 got r/u/d=%b busy=%b v=%0b want 100 busy[0]=0 v=0", {err_range, err_uuid, err_dup}, busy, out_valid); end
    tick();
    total++; if ({err_range, err_uuid, err_dup} !== 3'b000) begin bad++; $display("FAIL err_pulse_len got r/u/d=%b want 000", {err_range, err_uuid, err_dup}); end
    for (int i = 0; i < 4; i++) begin
      if (i != 1) begin
        drive(1'b1, 2'd1, 44'h50, 2'd1, 4'(i), 4'd4);
        tick();
      end
    end
    drive(1'b0, 2'd0, 44'h0, 2'd0, 4'd0, 4'd0);
    total++; if (out_valid !== 1'b1 || out_count !== 5'd4 || out_uuid !== 44'h50 || busy[1] !== 1'b0)
      begin bad++; $display("FAIL err_tracker_intact got v=%0b cnt=%0d uuid=%0h busy=%b want v=1 cnt=4 uuid=50 busy[1]=0", out_valid, out_count, out_uuid, busy); end
    tick();
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 2'd2, 44'h60, 2'd1, 4'd0, 4'd4);
    tick();
    drive(1'b1, 2'd2, 44'h60, 2'd1, 4'd1, 4'd4);
    tick();
    total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL mid_open got busy=%b want busy[2]=1", busy); end
    drive(1'b0, 2'd0, 44'h0, 2'd0, 4'd0, 4'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (busy !== 4'b0000 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset got busy=%b v=%0b want busy=0000 v=0", busy, out_valid); end
    drive(1'b1, 2'd2, 44'h61, 2'd1, 4'd0, 4'd1);
    tick();
    drive(1'b0, 2'd0, 44'h0, 2'd0, 4'd0, 4'd0);
    total++; if (out_valid !== 1'b1 || out_count !== 5'd1 || out_uuid !== 44'h61 || busy !== 4'b0000)
      begin bad++; $display("FAIL post_reset got v=%0b cnt=%0d uuid=%0h busy=%b want v=1 cnt=1 uuid=61 busy=0000", out_valid, out_count, out_uuid, busy); end
    tick();
  endtask

  initial begin
    test_reset();
    test_mload_back_to_back();
    test_mmul();
    test_normal_interleave();
    test_backpressure();
    test_errors();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
